md_queue: RTL and testbench
===========================

MD_QUEUE -- requirements
Module: md_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, memory data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, read-return queue entries; power of two, at least 2.
REQ-003 SHALL have parameter SPY_W, default 16, spy load slice width; WIDTH SHALL be an integer multiple of SPY_W.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- state_alu, state_write, state_mmu, state_fetch  in  1 each  machine cycle phase strobes.
- mem_valid  in  1  memory read-return strobe.
- mem_data  in  WIDTH  returned read data.
- mem_par  in  1  returned odd-parity bit.
- mem_ready  out  1  queue can accept a return.
- pop  in  1  move the queue head into md.
- destmdr  in  1  ALU destination is MD.
- alu_data  in  WIDTH  ALU result.
- spy_ld  in  WIDTH/SPY_W  one-hot spy slice load select.
- spy_in  in  SPY_W  spy write data.
- srcmd  in  1  MD selected as source.
- err_clr  in  1  clear sticky error flags.
- md  out  WIDTH  memory data register.
- mdhaspar  out  1  md holds a valid parity bit.
- mdpar  out  1  parity bit held with md.
- mddrive  out  1  md drives the source bus.
- q_count  out  clog2(DEPTH)+1  queue occupancy.
- overflow  out  1  sticky: a return was dropped.
- par_err  out  1  sticky: parity error on pop.

Function
REQ-005 SHALL implement a FIFO of DEPTH entries, each holding {mem_par, mem_data}.
REQ-006 SHALL drive mem_ready = (q_count != DEPTH), combinationally.
REQ-007 SHALL push on mem_valid when the queue is not full, or when it is full and a pop is accepted in the same cycle.
REQ-008 SHALL drop a mem_valid arriving on a full queue with no accepted pop, set overflow, and leave the queue unchanged.
REQ-009 SHALL accept pop only when q_count != 0; a pop on an empty queue SHALL be ignored and SHALL leave md, mdpar and mdhaspar unchanged.
REQ-010 SHALL NOT bypass the queue: a word pushed in cycle N SHALL become poppable in cycle N+1 at the earliest.
REQ-011 SHALL, on a simultaneous push and accepted pop, keep q_count unchanged and preserve FIFO order.
REQ-012 SHALL wrap the read and write pointers modulo DEPTH.
REQ-013 SHALL select the md load source by priority (highest first):
- state_alu & destmdr: md <= alu_data; mdpar <= ~^alu_data; mdhaspar <= 1.
- accepted pop: md <= head data; mdpar <= head parity; mdhaspar <= 1.
- any spy_ld bit set: only slice k loaded, md[k*SPY_W +: SPY_W] <= spy_in; mdhaspar <= 0.
REQ-014 SHALL still dequeue the head entry when an accepted pop coincides with an ALU load; the dequeued data SHALL be discarded.
REQ-015 SHALL update md one clock after the load condition, with no other latency.
REQ-016 SHALL drive mddrive = srcmd & (state_alu | state_write | state_mmu | state_fetch), combinationally.
REQ-017 SHALL clear overflow and par_err on err_clr.
REQ-018 SHALL set rather than clear a flag when its set condition coincides with err_clr.

Reset
REQ-019 SHALL, on reset, clear md, mdpar, mdhaspar, both pointers, q_count, overflow and par_err to 0.
REQ-020 SHALL give reset priority over every other input; a push or pop in a reset cycle SHALL be lost.

Configuration
REQ-021 SHALL support macro MD_QUEUE_PARITY_CHECK_EN.
- Defined: set par_err when an accepted pop has ^{mem_par, mem_data} == 0 (bad odd parity).
- Not defined: par_err is constant 0; mdpar and mdhaspar are constant 0; queue entries are WIDTH bits only.

Verification
REQ-022 SHALL cover push 0x12345678 (good parity), then pop: md=0x12345678, mdhaspar=1, q_count back to 0.
REQ-023 SHALL cover pushes A, B, C, D, then a fifth push with DEPTH=4: mem_ready=0 after D, overflow=1, pops return A, B, C, D.
REQ-024 SHALL cover a full queue with simultaneous push E and pop: md=A, q_count stays 4, E is popped last.
REQ-025 SHALL cover state_alu, destmdr, alu_data=0xFFFF0000 and pop in one cycle: md=0xFFFF0000, head dequeued, q_count decremented.
REQ-026 SHALL cover, with the macro defined, a push of 0x00000001 with mem_par=1 then pop: par_err=1; err_clr then clears it to 0.
REQ-027 SHALL cover spy_ld=2'b10, spy_in=0xBEEF on md=0: md=0xBEEF0000, mdhaspar=0; a pop on an empty queue leaves md unchanged.

Source files
------------

// File: rtl/md_queue.sv
// md_queue: memory read-return queue feeding the MD (memory data) register.
// Read returns are held in a small FIFO until popped into md. md can also be
// loaded from the ALU result or, one slice at a time, from the spy port.
// Optional build macro MD_QUEUE_PARITY_CHECK_EN: each queue entry also stores
// the returned odd-parity bit, md tracks its parity, and a pop of a bad-parity
// word sets par_err. Without the macro, mdpar, mdhaspar and par_err are held at 0.
module md_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SPY_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       state_alu,
    input  logic                       state_write,
    input  logic                       state_mmu,
    input  logic                       state_fetch,
    input  logic                       mem_valid,
    input  logic [WIDTH-1:0]           mem_data,
    input  logic                       mem_par,
    output logic                       mem_ready,
    input  logic                       pop,
    input  logic                       destmdr,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic [WIDTH/SPY_W-1:0]     spy_ld,
    input  logic [SPY_W-1:0]           spy_in,
    input  logic                       srcmd,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           md,
    output logic                       mdhaspar,
    output logic                       mdpar,
    output logic                       mddrive,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       overflow,
    output logic                       par_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NS = WIDTH / SPY_W;

`ifdef MD_QUEUE_PARITY_CHECK_EN
    localparam int EW     = WIDTH + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int EW     = WIDTH;
    localparam bit PAR_EN = 1'b0;
`endif

    logic [EW-1:0]    fifo_q [DEPTH];
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head_entry;
    logic [WIDTH-1:0] head_data;
    logic             head_par;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic             mdpar_q, mdpar_d;
    logic             mdhaspar_q, mdhaspar_d;
    logic             overflow_q, overflow_d;
    logic             par_err_q, par_err_d;

    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             drop;

    assign head_entry = fifo_q[rd_ptr_q];

`ifdef MD_QUEUE_PARITY_CHECK_EN
    assign wr_entry  = {mem_par, mem_data};
    assign head_data = head_entry[WIDTH-1:0];
    assign head_par  = head_entry[WIDTH];
`else
    logic unused_mem_par;
    assign unused_mem_par = mem_par;
    assign wr_entry  = mem_data;
    assign head_data = head_entry;
    assign head_par  = 1'b0;
`endif

    // A full queue can still take a return if the head leaves in the same cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign mem_ready = ~full;
    assign pop_ok    = pop & (count_q != '0);
    assign push_ok   = mem_valid & (~full | pop_ok);
    assign drop      = mem_valid & full & ~pop_ok;
    assign mddrive   = srcmd & (state_alu | state_write | state_mmu | state_fetch);

    // Next-state for pointers, occupancy, md and the sticky error flags.
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        md_d       = md_q;
        mdpar_d    = mdpar_q;
        mdhaspar_d = mdhaspar_q;
        if (state_alu && destmdr) begin
            // A coincident pop still dequeues; its word is simply discarded.
            md_d       = alu_data;
            mdpar_d    = PAR_EN & ~^alu_data;
            mdhaspar_d = PAR_EN;
        end else if (pop_ok) begin
            md_d       = head_data;
            mdpar_d    = PAR_EN & head_par;
            mdhaspar_d = PAR_EN;
        end else if (|spy_ld) begin
            for (int k = 0; k < NS; k++) begin
                if (spy_ld[k]) md_d[k*SPY_W +: SPY_W] = spy_in;
            end
            mdhaspar_d = 1'b0;
        end
        // Set wins over clear so an error in the clearing cycle is not lost.
        overflow_d = drop | (overflow_q & ~err_clr);
        par_err_d  = (PAR_EN & pop_ok & ~^{head_par, head_data}) | (par_err_q & ~err_clr);
    end

    // Queue storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) fifo_q[wr_ptr_q] <= wr_entry;
    end

    // Control and md registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            md_q       <= '0;
            mdpar_q    <= 1'b0;
            mdhaspar_q <= 1'b0;
            overflow_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            md_q       <= md_d;
            mdpar_q    <= mdpar_d;
            mdhaspar_q <= mdhaspar_d;
            overflow_q <= overflow_d;
            par_err_q  <= par_err_d;
        end
    end

    assign md       = md_q;
    assign mdpar    = mdpar_q;
    assign mdhaspar = mdhaspar_q;
    assign q_count  = count_q;
    assign overflow = overflow_q;
    assign par_err  = par_err_q;

endmodule

// File: tb/tb_md_queue.sv
// tb_md_queue: directed scenarios followed by random traffic for md_queue,
// checked every cycle against a queue-based reference model.
module tb_md_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SPY_W = 16;
    localparam int NS    = WIDTH / SPY_W;
`ifdef MD_QUEUE_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             state_alu, state_write, state_mmu, state_fetch;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_data;
    logic             mem_par;
    logic             mem_ready;
    logic             pop;
    logic             destmdr;
    logic [WIDTH-1:0] alu_data;
    logic [NS-1:0]    spy_ld;
    logic [SPY_W-1:0] spy_in;
    logic             srcmd;
    logic             err_clr;
    logic [WIDTH-1:0] md;
    logic             mdhaspar, mdpar, mddrive;
    logic [2:0]       q_count;
    logic             overflow, par_err;

    md_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPY_W(SPY_W)) dut (
        .clk(clk), .reset(reset),
        .state_alu(state_alu), .state_write(state_write),
        .state_mmu(state_mmu), .state_fetch(state_fetch),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_par(mem_par),
        .mem_ready(mem_ready), .pop(pop), .destmdr(destmdr),
        .alu_data(alu_data), .spy_ld(spy_ld), .spy_in(spy_in),
        .srcmd(srcmd), .err_clr(err_clr), .md(md), .mdhaspar(mdhaspar),
        .mdpar(mdpar), .mddrive(mddrive), .q_count(q_count),
        .overflow(overflow), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: queue entries are {parity, data}.
    logic [WIDTH:0]   mq[$];
    logic [WIDTH-1:0] m_md;
    logic             m_par, m_has, m_ov, m_pe;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic gp(input logic [WIDTH-1:0] d);
        return ~^d;
    endfunction

    task automatic idle();
        reset = 1'b0; state_alu = 1'b0; state_write = 1'b0; state_mmu = 1'b0;
        state_fetch = 1'b0; mem_valid = 1'b0; mem_data = '0; mem_par = 1'b0;
        pop = 1'b0; destmdr = 1'b0; alu_data = '0; spy_ld = '0; spy_in = '0;
        srcmd = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        mem_valid = 1'b1; mem_data = d; mem_par = gp(d);
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic tick();
        logic [WIDTH:0] head;
        bit pop_ok, full, ov_set, pe_set;
        #1;
        check("mddrive", mddrive, srcmd & (state_alu | state_write | state_mmu | state_fetch));
        if (!reset) check("mem_ready", mem_ready, mq.size() != DEPTH);
        if (reset) begin
            mq.delete();
            m_md = '0; m_par = 1'b0; m_has = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        end else begin
            pop_ok = pop && (mq.size() != 0);
            full   = (mq.size() == DEPTH);
            head   = pop_ok ? mq[0] : '0;
            ov_set = mem_valid && full && !pop_ok;
            pe_set = PAR && pop_ok && ((^head) == 1'b0);
            if (pop_ok) void'(mq.pop_front());
            if (mem_valid && !ov_set) mq.push_back({mem_par, mem_data});
            if (state_alu && destmdr) begin
                m_md = alu_data; m_par = PAR & ~^alu_data; m_has = PAR;
            end else if (pop_ok) begin
                m_md = head[WIDTH-1:0]; m_par = PAR & head[WIDTH]; m_has = PAR;
            end else if (spy_ld != '0) begin
                for (int k = 0; k < NS; k++)
                    if (spy_ld[k]) m_md[k*SPY_W +: SPY_W] = spy_in;
                m_has = 1'b0;
            end
            m_ov = ov_set | (m_ov & ~err_clr);
            m_pe = pe_set | (m_pe & ~err_clr);
        end
        @(posedge clk);
        #1;
        check("md", md, m_md);
        check("mdpar", mdpar, m_par);
        check("mdhaspar", mdhaspar, m_has);
        check("q_count", q_count, mq.size());
        check("overflow", overflow, m_ov);
        check("par_err", par_err, m_pe);
    endtask

    localparam logic [WIDTH-1:0] WA = 32'hA0A0_0001;
    localparam logic [WIDTH-1:0] WB = 32'hB0B0_0003;
    localparam logic [WIDTH-1:0] WC = 32'hC0C0_0007;
    localparam logic [WIDTH-1:0] WD = 32'hD0D0_000F;
    localparam logic [WIDTH-1:0] WE = 32'hE0E0_001F;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] fill [4];
        fill[0] = WA; fill[1] = WB; fill[2] = WC; fill[3] = WD;
        mq.delete();
        m_md = '0; m_par = 1'b0; m_has = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        idle();

        // Reset
        reset = 1'b1; tick(); tick(); idle();
        check("rst_md", md, 32'h0);
        check("rst_count", q_count, 3'd0);
        check("rst_ready", mem_ready, 1'b1);

        // Single push then pop
        push_word(32'h1234_5678); tick(); idle();
        check("one_count", q_count, 3'd1);
        pop = 1'b1; tick(); idle();
        check("one_md", md, 32'h1234_5678);
        check("one_has", mdhaspar, PAR);
        check("one_count0", q_count, 3'd0);

        // No bypass: push and pop on an empty queue, pop is ignored
        push_word(32'h5555_AAAA); pop = 1'b1; tick(); idle();
        check("nobyp_md", md, 32'h1234_5678);
        check("nobyp_count", q_count, 3'd1);
        pop = 1'b1; tick(); idle();
        check("nobyp_pop", md, 32'h5555_AAAA);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) begin push_word(fill[i]); tick(); end
        idle();
        check("full_ready", mem_ready, 1'b0);
        push_word(WE); tick(); idle();
        check("ovf_flag", overflow, 1'b1);
        check("ovf_count", q_count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; tick(); check("drain_md", md, fill[i]);
        end
        idle();

        // Clear error, refill, push and pop together on full queue
        err_clr = 1'b1; tick(); idle();
        check("ovf_clr", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin push_word(fill[i]); tick(); end
        idle();
        push_word(WE); pop = 1'b1; tick(); idle();
        check("pp_md", md, WA);
        check("pp_count", q_count, 3'd4);
        check("pp_noovf", overflow, 1'b0);
        pop = 1'b1; tick(); tick(); tick(); tick(); idle();
        check("pp_last", md, WE);

        // ALU load wins over a pop; the head is still dequeued
        push_word(WA); tick(); push_word(WB); tick(); idle();
        state_alu = 1'b1; destmdr = 1'b1; alu_data = 32'hFFFF_0000; pop = 1'b1;
        srcmd = 1'b1; tick(); idle();
        check("alu_md", md, 32'hFFFF_0000);
        check("alu_par", mdpar, PAR);
        check("alu_count", q_count, 3'd1);
        pop = 1'b1; tick(); idle();
        check("alu_next", md, WB);

        // Bad parity word; clear; set and clear in the same cycle
        mem_valid = 1'b1; mem_data = 32'h0000_0001; mem_par = 1'b1; tick(); idle();
        pop = 1'b1; tick(); idle();
        check("perr_set", par_err, PAR);
        err_clr = 1'b1; tick(); idle();
        check("perr_clr", par_err, 1'b0);
        mem_valid = 1'b1; mem_data = 32'h0000_0001; mem_par = 1'b1; tick(); idle();
        pop = 1'b1; err_clr = 1'b1; tick(); idle();
        check("perr_setwin", par_err, PAR);

        // Spy load on a freshly reset md, then pop on empty
        reset = 1'b1; tick(); idle();
        spy_ld = 2'b10; spy_in = 16'hBEEF; tick(); idle();
        check("spy_md", md, 32'hBEEF_0000);
        check("spy_has", mdhaspar, 1'b0);
        pop = 1'b1; state_fetch = 1'b1; srcmd = 1'b1; tick(); idle();
        check("empty_pop_md", md, 32'hBEEF_0000);
        check("empty_pop_cnt", q_count, 3'd0);

        // Push lost in a reset cycle
        push_word(WC); reset = 1'b1; tick(); idle();
        check("rst_push_lost", q_count, 3'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            reset       = ($urandom_range(99) == 0);
            mem_valid   = ($urandom_range(1) == 1);
            mem_data    = $urandom;
            mem_par     = ($urandom_range(7) == 0) ? ~gp(mem_data) : gp(mem_data);
            pop         = ($urandom_range(9) < 4);
            state_alu   = ($urandom_range(3) == 0);
            state_write = ($urandom_range(3) == 0);
            state_mmu   = ($urandom_range(3) == 0);
            state_fetch = ($urandom_range(3) == 0);
            destmdr     = ($urandom_range(2) == 0);
            alu_data    = $urandom;
            spy_ld      = ($urandom_range(3) == 0) ? NS'($urandom_range(3)) : '0;
            spy_in      = SPY_W'($urandom);
            srcmd       = ($urandom_range(1) == 1);
            err_clr     = ($urandom_range(19) == 0);
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
